// File: rtl/guitar_pkg.sv
// Shared constants and types for the GuitarZero note highway.
// Geometry and timing are in screen pixels and frame ticks.
package guitar_pkg;

    localparam int LANES      = 4;
    localparam int SLOTS      = 8;
    localparam int LANE_X0    = 160;
    localparam int LANE_PITCH = 80;
    localparam int NOTE_W     = 48;
    localparam int NOTE_H     = 16;
    localparam int SPEED      = 2;
    localparam int HIT_Y      = 420;
    localparam int HIT_TOL    = 12;
    localparam int Y_MAX      = 479;

    // Range of top-row y whose note centre lies within HIT_TOL of HIT_Y.
    localparam int HIT_Y_LO = HIT_Y - HIT_TOL - NOTE_H / 2;
    localparam int HIT_Y_HI = HIT_Y + HIT_TOL - NOTE_H / 2;

    localparam int MISS_W     = $clog2(SLOTS + 1);
    localparam int HIT_SUM_W  = $clog2(LANES + 1);
    localparam int MISS_SUM_W = $clog2(LANES * SLOTS + 1);

    typedef struct packed {
        logic       active;
        logic [9:0] y;
    } note_slot_t;

    typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/note_lane.sv
// One lane of falling notes: spawn into the lowest free slot, advance on
// frame ticks, clear on hit or when falling off screen, and draw itself.
module note_lane
    import guitar_pkg::*;
#(
    parameter int LANE_X = LANE_X0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              tick,
    input  logic              spawn,
    input  logic              key_edge,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    output logic              free,
    output logic              hit,
    output logic [MISS_W-1:0] miss,
    output logic              sprite
);

    note_slot_t       slots     [SLOTS];
    note_slot_t       slots_nxt [SLOTS];
    logic [10:0]      y_adv     [SLOTS];
    logic [SLOTS-1:0] in_window;
    logic [SLOTS-1:0] hit_sel;
    logic [SLOTS-1:0] spawn_sel;
    logic             seen_free;
    logic             seen_hit;
    logic             in_col;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        seen_free = 1'b0;
        seen_hit  = 1'b0;
        miss      = '0;
        for (int s = 0; s < SLOTS; s++) begin
            in_window[s] = slots[s].active &&
                           slots[s].y >= 10'(HIT_Y_LO) &&
                           slots[s].y <= 10'(HIT_Y_HI);
            hit_sel[s]   = in_window[s] && !seen_hit;
            seen_hit     = seen_hit | in_window[s];
            spawn_sel[s] = !slots[s].active && !seen_free;
            seen_free    = seen_free | !slots[s].active;
        end
        free = seen_free;
        hit  = key_edge & seen_hit;

        // Hit is judged on pre-tick positions; a hit slot is not advanced.
        for (int s = 0; s < SLOTS; s++) begin
            y_adv[s]     = {1'b0, slots[s].y} + 11'(SPEED);
            slots_nxt[s] = slots[s];
            if (key_edge && hit_sel[s]) begin
                slots_nxt[s].active = 1'b0;
            end else if (tick && slots[s].active) begin
                if (y_adv[s] > 11'(Y_MAX)) begin
                    slots_nxt[s].active = 1'b0;
                    miss = miss + MISS_W'(1);
                end else begin
                    slots_nxt[s].y = y_adv[s][9:0];
                end
            end
            if (spawn && spawn_sel[s]) begin
                slots_nxt[s].active = 1'b1;
                slots_nxt[s].y      = '0;
            end
        end
    end

    assign in_col = (DrawX >= 10'(LANE_X)) && (DrawX < 10'(LANE_X + NOTE_W));

    always_comb begin
        sprite = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            if (slots[s].active && in_col &&
                {1'b0, DrawY} >= {1'b0, slots[s].y} &&
                {1'b0, DrawY} <  {1'b0, slots[s].y} + 11'(NOTE_H)) begin
                sprite = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the slot array is reset in full because the active bits
            // must come up clear; it is small enough to live in flops.
            for (int s = 0; s < SLOTS; s++) begin
                slots[s] <= '0;
            end
        end else begin
            // NOTE: state updates use non-blocking assignments so every slot
            // sees the same pre-edge values.
            for (int s = 0; s < SLOTS; s++) begin
                slots[s] <= slots_nxt[s];
            end
        end
    end

endmodule

// File: rtl/note_highway.sv
// Falling-note engine feeding color_mapper: spawn handshake, frame-tick and
// key-edge detection, hit/miss scoring, and the per-pixel is_sprite flag.
module note_highway
    import guitar_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             spawn_valid,
    input  lane_idx_t        spawn_lane,
    output logic             spawn_ready,
    input  logic [LANES-1:0] key_press,
    input  logic [9:0]       DrawX,
    input  logic [9:0]       DrawY,
    output logic             is_sprite,
    output logic [LANES-1:0] hit_pulse,
    output logic [15:0]      score,
    output logic [7:0]       miss_count
);

    logic                  frame_clk_d;
    logic [LANES-1:0]      key_d;
    logic                  tick;
    logic [LANES-1:0]      key_edge;
    logic                  spawn_fire;
    logic [LANES-1:0]      lane_spawn;
    logic [LANES-1:0]      lane_free;
    logic [LANES-1:0]      lane_hit;
    logic [LANES-1:0]      lane_sprite;
    logic [MISS_W-1:0]     lane_miss [LANES];
    logic [HIT_SUM_W-1:0]  hit_sum;
    logic [MISS_SUM_W-1:0] miss_sum;
    logic [16:0]           score_sum;
    logic [8:0]            miss_total;

    // Delay registers reset high so levels held through reset are not edges.
    assign tick        = frame_clk & ~frame_clk_d;
    assign key_edge    = key_press & ~key_d;
    assign spawn_ready = ~tick & lane_free[spawn_lane];
    assign spawn_fire  = spawn_valid & spawn_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_spawn[l] = spawn_fire && (spawn_lane == lane_idx_t'(l));

        note_lane #(
            .LANE_X (LANE_X0 + l * LANE_PITCH)
        ) u_lane (
            .Clk      (Clk),
            .Reset    (Reset),
            .tick     (tick),
            .spawn    (lane_spawn[l]),
            .key_edge (key_edge[l]),
            .DrawX    (DrawX),
            .DrawY    (DrawY),
            .free     (lane_free[l]),
            .hit      (lane_hit[l]),
            .miss     (lane_miss[l]),
            .sprite   (lane_sprite[l])
        );
    end

    always_comb begin
        hit_sum  = '0;
        miss_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            hit_sum  = hit_sum + HIT_SUM_W'(lane_hit[l]);
            miss_sum = miss_sum + MISS_SUM_W'(lane_miss[l]);
        end
        score_sum  = {1'b0, score} + 17'(hit_sum);
        miss_total = {1'b0, miss_count} + 9'(miss_sum);
    end

    assign is_sprite = |lane_sprite;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d <= 1'b1;
            key_d       <= '1;
            hit_pulse   <= '0;
            score       <= '0;
            miss_count  <= '0;
        end else begin
            frame_clk_d <= frame_clk;
            key_d       <= key_press;
            hit_pulse   <= lane_hit;
            score       <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            miss_count  <= miss_total[8] ? 8'hFF : miss_total[7:0];
        end
    end

endmodule
